// File: rtl/tl45_register_read.sv
// tl45_register_read -- operand-fetch stage of the tl45 pipeline.
//
// Owns the 16 x 32-bit register file (r0 hard-wired to zero), takes the
// writeback port, resolves both source operands and registers the ALU input
// buffer. A read-after-write against the instruction currently in the buffer
// inserts one bubble and stalls decode.
//
// Build option: define TL45_RR_FORWARD_EN to enable the ALU-buffer and
// writeback bypasses. Without it operands come only from the array and the
// stage bubbles until the producer's writeback has landed.
//
// Ports:
//   i_clk, i_reset            clock, asynchronous active-high reset
//   i_pipe_stall/o_pipe_stall downstream stall in, stall to decode out
//   i_pipe_flush/o_pipe_flush flush in, forwarded upstream unchanged
//   i_opcode,i_dr,i_sr1,i_sr2,i_pc   decoded instruction (opcode 0 = NOP)
//   i_fwd_dr, i_fwd_val       ALU output buffer result (dr 0 = none)
//   i_wb_we,i_wb_dr,i_wb_val  writeback port
//   o_opcode..o_pc            registered ALU input buffer

// Per-source operand resolution. Reports a pending producer when bypassing
// is disabled so the top level can hold the instruction back.
module tl45_rr_operand (
   input  logic [3:0]  src,
   input  logic [3:0]  fwd_dr,
   input  logic [31:0] fwd_val,
   input  logic        wb_we,
   input  logic [3:0]  wb_dr,
   input  logic [31:0] wb_val,
   input  logic [31:0] rf_val,
   output logic [31:0] val,
   output logic        pending
);
`ifdef TL45_RR_FORWARD_EN
   always_comb begin
      val     = rf_val;
      pending = 1'b0;
      if (src == 4'd0)                    val = '0;
      else if (fwd_dr == src)             val = fwd_val;
      else if (wb_we && (wb_dr == src))   val = wb_val;
   end
`else
   logic unused_bypass;
   assign unused_bypass = ^{fwd_val, wb_val};

   always_comb begin
      val     = (src == 4'd0) ? '0 : rf_val;
      // src nonzero implies a matching fwd_dr is nonzero too
      pending = (src != 4'd0) &&
                ((fwd_dr == src) || (wb_we && (wb_dr == src)));
   end
`endif
endmodule

module tl45_register_read (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_pipe_stall,
   output logic        o_pipe_stall,
   input  logic        i_pipe_flush,
   output logic        o_pipe_flush,
   input  logic [4:0]  i_opcode,
   input  logic [3:0]  i_dr,
   input  logic [3:0]  i_sr1,
   input  logic [3:0]  i_sr2,
   input  logic [31:0] i_pc,
   input  logic [3:0]  i_fwd_dr,
   input  logic [31:0] i_fwd_val,
   input  logic        i_wb_we,
   input  logic [3:0]  i_wb_dr,
   input  logic [31:0] i_wb_val,
   output logic [4:0]  o_opcode,
   output logic [3:0]  o_dr,
   output logic [3:0]  o_sr1,
   output logic [3:0]  o_sr2,
   output logic [31:0] o_sr1_val,
   output logic [31:0] o_sr2_val,
   output logic [31:0] o_pc
);
   // rf[0] is never written, so it stays zero after reset
   logic [15:0][31:0] rf;
   logic [1:0][3:0]   src;
   logic [1:0][31:0]  opnd;
   logic [1:0]        pending;
   logic              valid_in, buf_valid, raw, hazard;

   assign src = {i_sr2, i_sr1};

   for (genvar g = 0; g < 2; g++) begin : g_opnd
      tl45_rr_operand u_opnd (
         .src     (src[g]),
         .fwd_dr  (i_fwd_dr),
         .fwd_val (i_fwd_val),
         .wb_we   (i_wb_we),
         .wb_dr   (i_wb_dr),
         .wb_val  (i_wb_val),
         .rf_val  (rf[src[g]]),
         .val     (opnd[g]),
         .pending (pending[g])
      );
   end

   assign valid_in  = (i_opcode != 5'd0);
   assign buf_valid = (o_opcode != 5'd0);
   // The buffered instruction has not reached the ALU output yet, so no
   // bypass can supply its result this cycle.
   assign raw    = buf_valid && (o_dr != 4'd0) &&
                   ((i_sr1 == o_dr) || (i_sr2 == o_dr));
   assign hazard = valid_in && (raw || (|pending));

   assign o_pipe_stall = i_pipe_stall | (hazard & ~i_pipe_flush);
   assign o_pipe_flush = i_pipe_flush;

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset)
         rf <= '0;
      else if (i_wb_we && (i_wb_dr != 4'd0))
         rf[i_wb_dr] <= i_wb_val;
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset || (!i_reset && i_pipe_flush)) begin
         o_opcode  <= '0;
         o_dr      <= '0;
         o_sr1     <= '0;
         o_sr2     <= '0;
         o_sr1_val <= '0;
         o_sr2_val <= '0;
         o_pc      <= '0;
      end else if (i_pipe_stall) begin
`ifdef TL45_RR_FORWARD_EN
         // Held operands would otherwise miss a writeback that lands while
         // the ALU is stalled.
         if (i_wb_we && (o_sr1 != 4'd0) && (i_wb_dr == o_sr1))
            o_sr1_val <= i_wb_val;
         if (i_wb_we && (o_sr2 != 4'd0) && (i_wb_dr == o_sr2))
            o_sr2_val <= i_wb_val;
`endif
      end else if (hazard) begin
         o_opcode  <= '0;
         o_dr      <= '0;
         o_sr1     <= '0;
         o_sr2     <= '0;
         o_sr1_val <= '0;
         o_sr2_val <= '0;
         o_pc      <= '0;
      end else begin
         o_opcode  <= i_opcode;
         o_dr      <= i_dr;
         o_sr1     <= i_sr1;
         o_sr2     <= i_sr2;
         o_sr1_val <= opnd[0];
         o_sr2_val <= opnd[1];
         o_pc      <= i_pc;
      end
   end
endmodule

// File: tb/tb_tl45_register_read.sv
// Self-checking bench for tl45_register_read: directed walk through the
// stage's key scenarios, then randomized traffic against a behavioural model.
// Follows TL45_RR_FORWARD_EN the same way the design does.
module tb_tl45_register_read;
`ifdef TL45_RR_FORWARD_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif

   logic        i_clk = 1'b0, i_reset = 1'b1;
   logic        i_pipe_stall = 0, i_pipe_flush = 0;
   logic        o_pipe_stall, o_pipe_flush;
   logic [4:0]  i_opcode = 0;
   logic [3:0]  i_dr = 0, i_sr1 = 0, i_sr2 = 0;
   logic [31:0] i_pc = 0;
   logic [3:0]  i_fwd_dr = 0;
   logic [31:0] i_fwd_val = 0;
   logic        i_wb_we = 0;
   logic [3:0]  i_wb_dr = 0;
   logic [31:0] i_wb_val = 0;
   logic [4:0]  o_opcode;
   logic [3:0]  o_dr, o_sr1, o_sr2;
   logic [31:0] o_sr1_val, o_sr2_val, o_pc;

   tl45_register_read dut (
      .i_clk(i_clk), .i_reset(i_reset),
      .i_pipe_stall(i_pipe_stall), .o_pipe_stall(o_pipe_stall),
      .i_pipe_flush(i_pipe_flush), .o_pipe_flush(o_pipe_flush),
      .i_opcode(i_opcode), .i_dr(i_dr), .i_sr1(i_sr1), .i_sr2(i_sr2), .i_pc(i_pc),
      .i_fwd_dr(i_fwd_dr), .i_fwd_val(i_fwd_val),
      .i_wb_we(i_wb_we), .i_wb_dr(i_wb_dr), .i_wb_val(i_wb_val),
      .o_opcode(o_opcode), .o_dr(o_dr), .o_sr1(o_sr1), .o_sr2(o_sr2),
      .o_sr1_val(o_sr1_val), .o_sr2_val(o_sr2_val), .o_pc(o_pc)
   );

   always #5 i_clk = ~i_clk;

   int n_cmp = 0, n_bad = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge i_clk);
      #1;
   endtask

   task automatic drive(input logic [4:0] op, input logic [3:0] dr, s1, s2,
                        input logic [31:0] pc);
      i_opcode = op; i_dr = dr; i_sr1 = s1; i_sr2 = s2; i_pc = pc;
   endtask

   task automatic env(input logic [3:0] fdr, input logic [31:0] fval,
                      input logic we, input logic [3:0] wdr, input logic [31:0] wval);
      i_fwd_dr = fdr; i_fwd_val = fval; i_wb_we = we; i_wb_dr = wdr; i_wb_val = wval;
   endtask

   task automatic chk_bubble(input string tag);
      chk({tag, "_op"},  32'(o_opcode),  0);
      chk({tag, "_dr"},  32'(o_dr),      0);
      chk({tag, "_v1"},  o_sr1_val,      0);
      chk({tag, "_v2"},  o_sr2_val,      0);
      chk({tag, "_pc"},  o_pc,           0);
   endtask

   // ---------------- behavioural reference ----------------
   typedef struct packed {
      logic [4:0]  op;
      logic [3:0]  dr, s1, s2;
      logic [31:0] v1, v2, pc;
   } buf_t;

   logic [31:0] m_rf [16];
   buf_t        mb;

   function automatic logic [31:0] m_opnd(input logic [3:0] s);
      if (s == 0) return 0;
      if (FWD && i_fwd_dr == s) return i_fwd_val;
      if (FWD && i_wb_we && i_wb_dr == s) return i_wb_val;
      return m_rf[s];
   endfunction

   // register a source would read is still in flight (no-bypass build only)
   function automatic bit m_inflight(input logic [3:0] s);
      return !FWD && s != 0 && (i_fwd_dr == s || (i_wb_we && i_wb_dr == s));
   endfunction

   function automatic bit m_hazard();
      bit dep;
      dep = (mb.op != 0 && mb.dr != 0 && (i_sr1 == mb.dr || i_sr2 == mb.dr))
            || m_inflight(i_sr1) || m_inflight(i_sr2);
      return (i_opcode != 0) && dep;
   endfunction

   task automatic m_edge;
      buf_t nb;
      nb = mb;
      if (i_pipe_flush) nb = '0;
      else if (i_pipe_stall) begin
         if (FWD && i_wb_we && mb.s1 != 0 && i_wb_dr == mb.s1) nb.v1 = i_wb_val;
         if (FWD && i_wb_we && mb.s2 != 0 && i_wb_dr == mb.s2) nb.v2 = i_wb_val;
      end else if (m_hazard()) nb = '0;
      else begin
         nb.op = i_opcode; nb.dr = i_dr; nb.s1 = i_sr1; nb.s2 = i_sr2;
         nb.v1 = m_opnd(i_sr1); nb.v2 = m_opnd(i_sr2); nb.pc = i_pc;
      end
      if (i_wb_we && i_wb_dr != 0) m_rf[i_wb_dr] = i_wb_val;
      mb = nb;
   endtask

   // ---------------- stimulus ----------------
   int stalls;
   bit issued;

   initial begin
      // reset state
      #12;
      chk_bubble("reset");
      chk("reset_stall", 32'(o_pipe_stall), 0);
      i_reset = 1'b0;
      tick();

      // write r3, then read it back through the array
      env(0, 0, 1, 3, 32'h12345678);
      drive(0, 0, 0, 0, 0);
      tick();
      env(0, 0, 0, 0, 0);
      drive(5'd1, 4'd7, 4'd3, 4'd0, 32'h100);
      tick();
      chk("rd_v1", o_sr1_val, 32'h12345678);
      chk("rd_v2", o_sr2_val, 0);
      chk("rd_dr", 32'(o_dr), 7);
      chk("rd_pc", o_pc, 32'h100);

      // r2 <- r1+r1 ; r4 <- r2+r2 with the producer moving down the pipe
      drive(5'd1, 4'd2, 4'd1, 4'd1, 32'h200);
      tick();
      drive(5'd1, 4'd4, 4'd2, 4'd2, 32'h204);
      stalls = 0; issued = 0;
      for (int k = 1; k <= 8; k++) begin
         if (k == 2)      env(2, 32'hA, 0, 0, 0);
         else if (k == 3) env(0, 0, 1, 2, 32'hA);
         else             env(0, 0, 0, 0, 0);
         #1;
         if (!o_pipe_stall) begin issued = 1; break; end
         stalls++;
         tick();
         chk("dep_bubble", 32'(o_opcode), 0);
      end
      chk("dep_stalls", stalls, FWD ? 1 : 3);
      chk("dep_issued", 32'(issued), 1);
      tick();
      chk("dep_v1", o_sr1_val, 32'hA);
      chk("dep_v2", o_sr2_val, 32'hA);
      chk("dep_dr", 32'(o_dr), 4);

      // downstream stall for 3 cycles while r5 is written back
      env(0, 0, 0, 0, 0);
      drive(5'd2, 4'd6, 4'd0, 4'd5, 32'h300);
      tick();
      i_pipe_stall = 1;
      drive(5'd3, 4'd1, 4'd1, 4'd1, 32'h999);
      for (int j = 0; j < 3; j++) begin
         env(0, 0, j == 0, 5, 32'hDEAD);
         #1;
         chk("stl_out", 32'(o_pipe_stall), 1);
         tick();
         chk("stl_op", 32'(o_opcode), 2);
         chk("stl_dr", 32'(o_dr), 6);
         chk("stl_pc", o_pc, 32'h300);
         chk("stl_v2", o_sr2_val, FWD ? 32'hDEAD : 32'h0);
      end

      // flush + stall + pending hazard against buffered r6
      env(0, 0, 0, 0, 0);
      i_pipe_flush = 1;
      drive(5'd3, 4'd1, 4'd6, 4'd0, 32'h400);
      #1;
      chk("fl_stall", 32'(o_pipe_stall), 1);
      chk("fl_flush", 32'(o_pipe_flush), 1);
      i_pipe_stall = 0;
      #1;
      chk("fl_nostall", 32'(o_pipe_stall), 0);
      i_pipe_stall = 1;
      tick();
      chk_bubble("flush");
      i_pipe_flush = 0; i_pipe_stall = 0;

      // writes to r0 are dropped
      env(0, 0, 1, 0, 32'hFFFFFFFF);
      drive(0, 0, 0, 0, 0);
      tick();
      env(0, 0, 0, 0, 0);
      drive(5'd1, 4'd3, 4'd0, 4'd3, 32'h500);
      tick();
      chk("r0_v1", o_sr1_val, 0);
      chk("r0_r3", o_sr2_val, 32'h12345678);

      // asynchronous reset mid-cycle with a valid buffer
      #2 i_reset = 1;
      #1;
      chk_bubble("areset");
      i_reset = 0;
      tick();
      drive(5'd1, 4'd5, 4'd3, 4'd0, 32'h600);
      tick();
      chk("areset_r3", o_sr1_val, 0);

      // randomized traffic against the model
      i_reset = 1;
      drive(0, 0, 0, 0, 0);
      env(0, 0, 0, 0, 0);
      #2 i_reset = 0;
      mb = '0;
      for (int r = 0; r < 16; r++) m_rf[r] = 0;
      tick();
      for (int c = 0; c < 400; c++) begin
         drive(($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
               4'($urandom_range(0, 7)), 4'($urandom_range(0, 7)),
               4'($urandom_range(0, 7)), $urandom);
         env(($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(1, 7)), $urandom,
             1'($urandom_range(0, 1)), 4'($urandom_range(0, 7)), $urandom);
         i_pipe_stall = ($urandom_range(0, 4) == 0);
         i_pipe_flush = ($urandom_range(0, 15) == 0);
         #1;
         chk("rnd_stall", 32'(o_pipe_stall),
             32'(i_pipe_stall | (m_hazard() & ~i_pipe_flush)));
         chk("rnd_flush", 32'(o_pipe_flush), 32'(i_pipe_flush));
         @(posedge i_clk);
         m_edge();
         #1;
         chk("rnd_op",  32'(o_opcode), 32'(mb.op));
         chk("rnd_dr",  32'(o_dr),     32'(mb.dr));
         chk("rnd_sr1", 32'(o_sr1),    32'(mb.s1));
         chk("rnd_sr2", 32'(o_sr2),    32'(mb.s2));
         chk("rnd_v1",  o_sr1_val,     mb.v1);
         chk("rnd_v2",  o_sr2_val,     mb.v2);
         chk("rnd_pc",  o_pc,          mb.pc);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
